// File: rtl/vending_pkg.sv
// Shared types and widths for the single-product vending controller.
package vending_pkg;

  localparam int CREDIT_W = 5;
  localparam int COIN_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

endpackage

// File: rtl/vending_fsm.sv
// Vending controller: accumulates coin credit, pulses dispense with change at price,
// refunds on request. All outputs are registered alongside the state.
module vending_fsm
  import vending_pkg::*;
#(
  parameter int PRICE = 10
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              coinInserted,
  input  logic [COIN_W-1:0] money,
  input  logic              returnMoney,
  output logic [COIN_W-1:0] coinReturn,
  output logic              dispense
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t                r_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic                  r_dispense;
  logic [COIN_W-1:0]     r_coinReturn;

  state_t                w_nextState;
  logic [CREDIT_W-1:0]   w_nextCredit;
  logic                  w_nextDispense;
  logic [COIN_W-1:0]     w_nextCoinReturn;
  logic                  w_deposit;
  logic [CREDIT_W-1:0]   w_sum;
  logic                  w_reachPrice;
  logic [COIN_W-1:0]     w_change;

  // Credit is at most PRICE-1 before a deposit, so the 5-bit sum never wraps.
  assign w_deposit    = coinInserted && (money != '0) && !returnMoney;
  assign w_sum        = r_credit + CREDIT_W'(money);
  assign w_reachPrice = (w_sum >= PRICE_C);
  assign w_change     = COIN_W'(w_sum - PRICE_C);

  always_comb begin
    w_nextState  = r_state;
    w_nextCredit = r_credit;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (r_state == COLLECT && returnMoney) begin
          w_nextState  = REFUND;
          w_nextCredit = '0;
        end else if (w_deposit) begin
          if (w_reachPrice) begin
            w_nextState  = VEND;
            w_nextCredit = '0;
          end else begin
            w_nextState  = COLLECT;
            w_nextCredit = w_sum;
          end
        end
      end
      VEND, REFUND: begin
        w_nextState  = IDLE;
        w_nextCredit = '0;
      end
      default: begin
        w_nextState  = IDLE;
        w_nextCredit = '0;
      end
    endcase
  end

  // Output values for the cycle that follows the next edge.
  always_comb begin
    w_nextDispense   = 1'b0;
    w_nextCoinReturn = '0;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (r_state == COLLECT && returnMoney) begin
          w_nextCoinReturn = COIN_W'(r_credit);
        end else if (w_deposit && w_reachPrice) begin
          w_nextDispense   = 1'b1;
          w_nextCoinReturn = w_change;
        end
      end
      default: begin
        w_nextDispense   = 1'b0;
        w_nextCoinReturn = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_dispense   <= 1'b0;
      r_coinReturn <= '0;
    end else begin
      r_state      <= w_nextState;
      r_credit     <= w_nextCredit;
      r_dispense   <= w_nextDispense;
      r_coinReturn <= w_nextCoinReturn;
    end
  end

  assign dispense   = r_dispense;
  assign coinReturn = r_coinReturn;

endmodule

// File: tb/tb_vending_fsm.sv
// Directed bench for vending_fsm at PRICE=10; expected state, credit and
// outputs are hand-computed per step.
module tb_vending_fsm;
  import vending_pkg::*;

  logic              clock;
  logic              resetN;
  logic              coinInserted;
  logic [COIN_W-1:0] money;
  logic              returnMoney;
  logic [COIN_W-1:0] coinReturn;
  logic              dispense;

  int checkCount = 0;
  int errorCount = 0;

  vending_fsm #(.PRICE(10)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .coinInserted(coinInserted),
    .money       (money),
    .returnMoney (returnMoney),
    .coinReturn  (coinReturn),
    .dispense    (dispense)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic coin, input logic [3:0] m, input logic ret);
    coinInserted = coin;
    money        = m;
    returnMoney  = ret;
    @(posedge clock);
    #1;
  endtask

  // Credit is only meaningful outside the one-cycle VEND/REFUND states.
  task automatic expectAll(input string tag, input state_t st, input int credit,
                           input logic disp, input int ret);
    checkOutput({tag, ".state"}, 8'(dut.r_state), 8'(st));
    checkOutput({tag, ".dispense"}, 8'(dispense), 8'(disp));
    checkOutput({tag, ".coinReturn"}, 8'(coinReturn), 8'(ret));
    if (st == IDLE || st == COLLECT)
      checkOutput({tag, ".credit"}, 8'(dut.r_credit), 8'(credit));
  endtask

  initial begin
    resetN       = 1'b0;
    coinInserted = 1'b0;
    money        = '0;
    returnMoney  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expectAll("reset", IDLE, 0, 1'b0, 0);
    #4 resetN = 1'b1;

    // Asynchronous reset mid-COLLECT, then a fresh deposit.
    applyStimulus(1'b1, 4'd6, 1'b0);  expectAll("rst_c6", COLLECT, 6, 1'b0, 0);
    #3 resetN = 1'b0;
    #1 expectAll("rst_async", IDLE, 0, 1'b0, 0);
    #2 resetN = 1'b1;
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("rst_c4", COLLECT, 4, 1'b0, 0);

    // Exact price: 4 then 6.
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("ex_hold", COLLECT, 4, 1'b0, 0);
    applyStimulus(1'b1, 4'd6, 1'b0);  expectAll("ex_vend", VEND, 0, 1'b1, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("ex_idle", IDLE, 0, 1'b0, 0);

    // Held coin of 4: 4, 8, VEND change 2, dropped coin, repeat.
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_c4", COLLECT, 4, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_c8", COLLECT, 8, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_vend", VEND, 0, 1'b1, 2);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_drop", IDLE, 0, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_c4b", COLLECT, 4, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_c8b", COLLECT, 8, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b0);  expectAll("ch_vendb", VEND, 0, 1'b1, 2);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("ch_idle", IDLE, 0, 1'b0, 0);

    // Refund of 3+5.
    applyStimulus(1'b1, 4'd3, 1'b0);  expectAll("rf_c3", COLLECT, 3, 1'b0, 0);
    applyStimulus(1'b1, 4'd5, 1'b0);  expectAll("rf_c8", COLLECT, 8, 1'b0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1);  expectAll("rf_ref", REFUND, 0, 1'b0, 8);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("rf_idle", IDLE, 0, 1'b0, 0);

    // Refund wins over a same-cycle coin.
    applyStimulus(1'b1, 4'd7, 1'b0);  expectAll("pr_c7", COLLECT, 7, 1'b0, 0);
    applyStimulus(1'b1, 4'd4, 1'b1);  expectAll("pr_ref", REFUND, 0, 1'b0, 7);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("pr_idle", IDLE, 0, 1'b0, 0);

    // Large coin straight from IDLE.
    applyStimulus(1'b1, 4'd15, 1'b0); expectAll("m15_vend", VEND, 0, 1'b1, 5);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("m15_idle", IDLE, 0, 1'b0, 0);

    // Zero-valued coins are ignored in IDLE and COLLECT.
    applyStimulus(1'b1, 4'd0, 1'b0);  expectAll("z_idle", IDLE, 0, 1'b0, 0);
    applyStimulus(1'b1, 4'd2, 1'b0);  expectAll("z_c2", COLLECT, 2, 1'b0, 0);
    applyStimulus(1'b1, 4'd0, 1'b0);  expectAll("z_hold", COLLECT, 2, 1'b0, 0);
    applyStimulus(1'b0, 4'd0, 1'b1);  expectAll("z_ref", REFUND, 0, 1'b0, 2);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("z_end", IDLE, 0, 1'b0, 0);

    // returnMoney in IDLE, alone and with a coin: nothing happens.
    applyStimulus(1'b0, 4'd0, 1'b1);  expectAll("ri_none", IDLE, 0, 1'b0, 0);
    applyStimulus(1'b1, 4'd5, 1'b1);  expectAll("ri_coin", IDLE, 0, 1'b0, 0);

    // Single exact coin, then maximum change 9+15.
    applyStimulus(1'b1, 4'd10, 1'b0); expectAll("m10_vend", VEND, 0, 1'b1, 0);
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("m10_idle", IDLE, 0, 1'b0, 0);
    applyStimulus(1'b1, 4'd9, 1'b0);  expectAll("mx_c9", COLLECT, 9, 1'b0, 0);
    applyStimulus(1'b1, 4'd15, 1'b0); expectAll("mx_vend", VEND, 0, 1'b1, 14);

    // Reset during VEND aborts the pulse immediately.
    #3 resetN = 1'b0;
    #1 expectAll("rv_async", IDLE, 0, 1'b0, 0);
    #2 resetN = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);  expectAll("rv_idle", IDLE, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
